multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; the sequential successor to the single-cycle
//  opcode decoder. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction, drives all datapath
//  strobes and handshakes with a variable-latency unified memory via mem_ready, with a bounded wait.
// PARAMETERS
//  OPCODE_W   6   instruction opcode width
//  ALUOP_W    2   ALU-control op width (00 add, 01 sub, 10 use funct; upper bits 0)
//  TIMEOUT    15  max cycles waiting on mem_ready before abort (1..2^16-1)
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         asynchronous, active-high reset
//  opcode       in   OPCODE_W  IR[31:26], valid from DECODE onward
//  mem_ready    in   1         memory access completes this cycle
//  pc_write     out  1         unconditional PC load
//  branch       out  1         PC load if ALU zero (beq)
//  branch_ne    out  1         PC load if ALU !zero (bne; 0 when feature off)
//  iord         out  1         memory address: 0=PC, 1=ALUOut
//  mem_read     out  1         memory read request
//  mem_write    out  1         memory write request
//  ir_write     out  1         load IR
//  reg_dst      out  1         write reg: 0=rt, 1=rd
//  mem_to_reg   out  1         write data: 0=ALUOut, 1=MDR
//  reg_write    out  1         register file write
//  alu_src_a    out  1         0=PC, 1=regA
//  alu_src_b    out  2         00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op       out  ALUOP_W   ALU-control op
//  pc_src       out  2         00 ALU, 01 ALUOut, 10 jump target
//  illegal_op   out  1         1-cycle pulse: unknown opcode in DECODE
//  mem_timeout  out  1         1-cycle pulse: TIMEOUT expired
//  state        out  4         current state (debug)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTEX=6 RTWB=7 BREX=8 JEX=9 ADDIEX=10 ADDIWB=11
//  - Reset (async): state<=FETCH, wait counter<=0; while reset high every output is 0, state=0.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write
//    asserted only in the cycle mem_ready=1, then ->DECODE; else stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode:
//    35,43->MEMADR; 0->RTEX; 4->BREX; 2->JEX; 8->ADDIEX; other->FETCH with illegal_op=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; ->MEMRD if lw else MEMWR.
//  - MEMRD: mem_read=1, iord=1; on mem_ready ->MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 ->FETCH.
//  - MEMWR: mem_write=1, iord=1; on mem_ready ->FETCH.
//  - RTEX: alu_src_a=1, alu_src_b=00, alu_op=10 ->RTWB. RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 ->FETCH.
//  - BREX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 (beq) ->FETCH.
//  - JEX: pc_write=1, pc_src=10 ->FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 ->ADDIWB. ADDIWB: reg_write=1, reg_dst=0 ->FETCH.
//  - Unlisted outputs are 0 in each state; outputs are combinational from state (+mem_ready gating).
//  - Wait counter: clears on entry to FETCH/MEMRD/MEMWR, increments each cycle there without mem_ready.
//    Reaching TIMEOUT with mem_ready=0: mem_timeout=1 that cycle, no ir/pc/reg strobe, ->FETCH.
//    mem_ready=1 in the same cycle as expiry wins: normal completion, no mem_timeout.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored. Reset mid-instruction aborts immediately to FETCH.
// CONFIGURATION
//  - MULTICYCLE_CTRL_BNE_EN defined: opcode 5 in DECODE ->BREX with branch_ne=1, branch=0.
//  - Undefined: opcode 5 is illegal (illegal_op pulse, ->FETCH); branch_ne tied 0.
// TESTING
//  - reset high then release, mem_ready=1 -> state 0 during reset, all outputs 0; FETCH->DECODE in 1 cycle.
//  - lw (op 35), mem_ready=1 always -> states 0,1,2,3,4,0 (5 cycles); MEMWB reg_write=1, mem_to_reg=1.
//  - sw (op 43), mem_ready held 0 three cycles in MEMWR -> mem_write high 4 cycles, then FETCH.
//  - R-type (op 0) -> 0,1,6,7,0; RTEX alu_op=10; RTWB reg_dst=1, reg_write=1. j (op 2) -> JEX pc_src=10.
//  - mem_ready stuck 0 in FETCH, TIMEOUT=15 -> mem_timeout pulse at 15th wait cycle, ir_write never high.
//  - op 5: BNE_EN on -> BREX with branch_ne=1; off -> illegal_op pulse in DECODE, next state FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle MIPS datapath. Each instruction walks
// through FETCH / DECODE / EXECUTE / MEM / WRITEBACK states. The FSM drives
// every datapath strobe from the current state. It handshakes with a
// variable-latency unified memory through mem_ready, and gives up on a
// memory access after TIMEOUT cycles without a response.
//
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN
//   When defined, opcode 5 (bne) is decoded into BREX with branch_ne=1.
//   When undefined, opcode 5 is illegal and branch_ne is always 0.
//
// Parameters:
//   OPCODE_W  instruction opcode width
//   ALUOP_W   ALU-control op width (00 add, 01 sub, 10 use funct)
//   TIMEOUT   maximum cycles spent waiting on mem_ready (1..65535)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   opcode       IR[31:26], valid from DECODE onward
//   mem_ready    memory access completes this cycle
//   pc_write     unconditional PC load
//   branch       PC load if ALU zero (beq)
//   branch_ne    PC load if ALU not zero (bne)
//   iord         memory address select: 0=PC, 1=ALUOut
//   mem_read     memory read request
//   mem_write    memory write request
//   ir_write     load IR
//   reg_dst      write register select: 0=rt, 1=rd
//   mem_to_reg   write data select: 0=ALUOut, 1=MDR
//   reg_write    register file write
//   alu_src_a    ALU A select: 0=PC, 1=regA
//   alu_src_b    ALU B select: 00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
//   alu_op       ALU-control op
//   pc_src       PC source: 00 ALU, 01 ALUOut, 10 jump target
//   illegal_op   one-cycle pulse: unknown opcode seen in DECODE
//   mem_timeout  one-cycle pulse: memory wait expired
//   state        current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                branch_ne,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BREX   = 4'd8,
    S_JEX    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  // The counter holds the number of cycles already waited. The wait
  // expires in the cycle where the counter reaches TIMEOUT-1, which is the
  // TIMEOUT-th cycle spent waiting.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      cur_state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic        waiting;
  logic        expired;

  assign state = cur_state;

  // The three memory-access states share one wait counter. A mem_ready
  // that arrives in the expiry cycle still completes the access normally.
  assign waiting = (cur_state == S_FETCH) || (cur_state == S_MEMRD) ||
                   (cur_state == S_MEMWR);
  assign expired = waiting && !mem_ready && (wait_cnt == WAIT_LAST);

  // State register and wait counter. The counter clears whenever a wait
  // state is entered or re-entered, including the FETCH->FETCH restart
  // after a timeout. It only counts while the FSM sits in a wait state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      if (waiting && (next_state == cur_state) && !expired)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Next-state and strobe decode. Every output defaults to 0. While reset
  // is high, nothing is decoded, so all strobes stay low even though the
  // register already holds FETCH.
  always_comb begin
    next_state  = cur_state;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALU_ADD;
    pc_src      = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    if (!reset) begin
      unique case (cur_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end else if (expired) begin
            mem_timeout = 1'b1;
            next_state  = S_FETCH;
          end
        end
        S_DECODE: begin
          // The branch target is computed here so BREX can use ALUOut.
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE:     next_state = S_RTEX;
            OP_BEQ:       next_state = S_BREX;
            OP_J:         next_state = S_JEX;
            OP_ADDI:      next_state = S_ADDIEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
            OP_BNE:       next_state = S_BREX;
`endif
            default: begin
              illegal_op = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready)
            next_state = S_MEMWB;
          else if (expired) begin
            mem_timeout = 1'b1;
            next_state  = S_FETCH;
          end
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready)
            next_state = S_FETCH;
          else if (expired) begin
            mem_timeout = 1'b1;
            next_state  = S_FETCH;
          end
        end
        S_RTEX: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_FUNCT;
          next_state = S_RTWB;
        end
        S_RTWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          next_state = S_FETCH;
        end
        S_BREX: begin
          // beq and bne share this state. The held opcode selects which
          // flavour of conditional PC load is requested.
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b01;
`ifdef MULTICYCLE_CTRL_BNE_EN
          branch_ne = (opcode == OP_BNE);
          branch    = (opcode != OP_BNE);
`else
          branch    = 1'b1;
`endif
          next_state = S_FETCH;
        end
        S_JEX: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          next_state = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control with the default parameters
// (TIMEOUT = 15). Every cycle, a step drives reset/mem_ready/opcode just
// after the rising edge. At the same time it pushes the expected 23-bit
// control word onto a scoreboard queue. At the falling edge the word is
// popped and compared against the packed DUT outputs.
// Honours MULTICYCLE_CTRL_BNE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  typedef logic [22:0] word_t;

  // Bit positions of each output inside the packed control word.
  localparam int PCW  = 22;
  localparam int BR   = 21;
  localparam int BRNE = 20;
  localparam int IORD = 19;
  localparam int MR   = 18;
  localparam int MW   = 17;
  localparam int IRW  = 16;
  localparam int RDST = 15;
  localparam int M2R  = 14;
  localparam int RW   = 13;
  localparam int ASA  = 12;
  localparam int ASB  = 10;
  localparam int AOP  = 8;
  localparam int PSRC = 6;
  localparam int ILL  = 5;
  localparam int TMO  = 4;

  // Expected control words, one per state flavour.
  localparam word_t W_RESET      = word_t'(0);
  localparam word_t W_FETCH_WAIT = word_t'((1 << MR) | (1 << ASB) | 0);
  localparam word_t W_FETCH_DONE = word_t'((1 << MR) | (1 << ASB) | (1 << IRW) | (1 << PCW) | 0);
  localparam word_t W_FETCH_TMO  = word_t'((1 << MR) | (1 << ASB) | (1 << TMO) | 0);
  localparam word_t W_DECODE     = word_t'((3 << ASB) | 1);
  localparam word_t W_DECODE_ILL = word_t'((3 << ASB) | (1 << ILL) | 1);
  localparam word_t W_MEMADR     = word_t'((1 << ASA) | (2 << ASB) | 2);
  localparam word_t W_MEMRD      = word_t'((1 << MR) | (1 << IORD) | 3);
  localparam word_t W_MEMRD_TMO  = word_t'((1 << MR) | (1 << IORD) | (1 << TMO) | 3);
  localparam word_t W_MEMWB      = word_t'((1 << RW) | (1 << M2R) | 4);
  localparam word_t W_MEMWR      = word_t'((1 << MW) | (1 << IORD) | 5);
  localparam word_t W_RTEX       = word_t'((1 << ASA) | (2 << AOP) | 6);
  localparam word_t W_RTWB       = word_t'((1 << RW) | (1 << RDST) | 7);
  localparam word_t W_BEQ        = word_t'((1 << ASA) | (1 << AOP) | (1 << PSRC) | (1 << BR) | 8);
  localparam word_t W_BNE        = word_t'((1 << ASA) | (1 << AOP) | (1 << PSRC) | (1 << BRNE) | 8);
  localparam word_t W_JEX        = word_t'((1 << PCW) | (2 << PSRC) | 9);
  localparam word_t W_ADDIEX     = word_t'((1 << ASA) | (2 << ASB) | 10);
  localparam word_t W_ADDIWB     = word_t'((1 << RW) | 11);

  typedef struct {
    logic       rst;
    logic       ready;
    logic [5:0] op;
    word_t      exp;
  } step_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       illegal_op, mem_timeout;
  logic [3:0] state;

  word_t sb[$];
  int    vectors;
  int    miscompares;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .state      (state)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t st(input logic r, input logic rdy, input logic [5:0] op,
                               input word_t e);
    step_t s;
    s.rst   = r;
    s.ready = rdy;
    s.op    = op;
    s.exp   = e;
    return s;
  endfunction

  function automatic word_t observed();
    return {pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_src, illegal_op, mem_timeout, state};
  endfunction

  // Drives one cycle of stimulus just after the rising edge and records
  // what the outputs must look like for that cycle.
  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    reset     = s.rst;
    mem_ready = s.ready;
    opcode    = s.op;
    sb.push_back(s.exp);
  endtask

  // Reset holds every output at 0. Release goes FETCH->DECODE in one cycle.
  // A reset asserted mid-instruction aborts to FETCH. A jump then finishes
  // back in FETCH.
  task automatic test_reset();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(1, 1, 6'd0, W_RESET));
    seq.push_back(st(1, 1, 6'd0, W_RESET));
    seq.push_back(st(0, 1, 6'd0, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd0, W_DECODE));
    seq.push_back(st(1, 1, 6'd0, W_RESET));
    seq.push_back(st(0, 0, 6'd0, W_FETCH_WAIT));
    seq.push_back(st(0, 1, 6'd0, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd2, W_DECODE));
    seq.push_back(st(0, 1, 6'd2, W_JEX));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_reset step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // lw with an always-ready memory: states 0,1,2,3,4, then back to FETCH.
  task automatic test_lw();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(0, 1, 6'd35, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd35, W_DECODE));
    seq.push_back(st(0, 1, 6'd35, W_MEMADR));
    seq.push_back(st(0, 1, 6'd35, W_MEMRD));
    seq.push_back(st(0, 1, 6'd35, W_MEMWB));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_lw step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // sw with three not-ready cycles in MEMWR keeps mem_write up for 4 cycles.
  // mem_ready in DECODE/MEMADR is ignored.
  task automatic test_sw_wait();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(0, 1, 6'd43, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd43, W_DECODE));
    seq.push_back(st(0, 1, 6'd43, W_MEMADR));
    for (int k = 0; k < 3; k++) seq.push_back(st(0, 0, 6'd43, W_MEMWR));
    seq.push_back(st(0, 1, 6'd43, W_MEMWR));
    seq.push_back(st(0, 0, 6'd43, W_FETCH_WAIT));
    seq.push_back(st(0, 1, 6'd43, W_FETCH_DONE));
    seq.push_back(st(0, 0, 6'd2, W_DECODE));
    seq.push_back(st(0, 0, 6'd2, W_JEX));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_sw_wait step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // R-type (0,1,6,7) and addi (0,1,10,11).
  task automatic test_rtype_addi();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(0, 1, 6'd0, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd0, W_DECODE));
    seq.push_back(st(0, 1, 6'd0, W_RTEX));
    seq.push_back(st(0, 1, 6'd0, W_RTWB));
    seq.push_back(st(0, 1, 6'd8, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd8, W_DECODE));
    seq.push_back(st(0, 1, 6'd8, W_ADDIEX));
    seq.push_back(st(0, 1, 6'd8, W_ADDIWB));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_rtype_addi step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // beq, opcode 5 (bne or illegal depending on build), and an illegal opcode.
  task automatic test_branch_illegal();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(0, 1, 6'd4, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd4, W_DECODE));
    seq.push_back(st(0, 1, 6'd4, W_BEQ));
    seq.push_back(st(0, 1, 6'd5, W_FETCH_DONE));
`ifdef MULTICYCLE_CTRL_BNE_EN
    seq.push_back(st(0, 1, 6'd5, W_DECODE));
    seq.push_back(st(0, 1, 6'd5, W_BNE));
`else
    seq.push_back(st(0, 1, 6'd5, W_DECODE_ILL));
`endif
    seq.push_back(st(0, 1, 6'd63, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd63, W_DECODE_ILL));
    seq.push_back(st(0, 0, 6'd63, W_FETCH_WAIT));
    seq.push_back(st(0, 1, 6'd2, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd2, W_DECODE));
    seq.push_back(st(0, 1, 6'd2, W_JEX));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_branch_illegal step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // Timeout in FETCH at the 15th wait cycle, and timeout in MEMRD.
  // mem_ready arriving exactly in the 15th cycle completes normally.
  task automatic test_timeout();
    step_t seq[$];
    word_t e, g;
    for (int k = 0; k < 14; k++) seq.push_back(st(0, 0, 6'd35, W_FETCH_WAIT));
    seq.push_back(st(0, 0, 6'd35, W_FETCH_TMO));
    seq.push_back(st(0, 1, 6'd35, W_FETCH_DONE));
    seq.push_back(st(0, 0, 6'd35, W_DECODE));
    seq.push_back(st(0, 0, 6'd35, W_MEMADR));
    for (int k = 0; k < 14; k++) seq.push_back(st(0, 0, 6'd35, W_MEMRD));
    seq.push_back(st(0, 0, 6'd35, W_MEMRD_TMO));
    for (int k = 0; k < 14; k++) seq.push_back(st(0, 0, 6'd2, W_FETCH_WAIT));
    seq.push_back(st(0, 1, 6'd2, W_FETCH_DONE));
    seq.push_back(st(0, 0, 6'd2, W_DECODE));
    seq.push_back(st(0, 0, 6'd2, W_JEX));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_timeout step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  // Back-to-back instructions with no idle cycles: sw, lw, j.
  task automatic test_back_to_back();
    step_t seq[$];
    word_t e, g;
    seq.push_back(st(0, 1, 6'd43, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd43, W_DECODE));
    seq.push_back(st(0, 1, 6'd43, W_MEMADR));
    seq.push_back(st(0, 1, 6'd43, W_MEMWR));
    seq.push_back(st(0, 1, 6'd35, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd35, W_DECODE));
    seq.push_back(st(0, 1, 6'd35, W_MEMADR));
    seq.push_back(st(0, 1, 6'd35, W_MEMRD));
    seq.push_back(st(0, 1, 6'd35, W_MEMWB));
    seq.push_back(st(0, 1, 6'd2, W_FETCH_DONE));
    seq.push_back(st(0, 1, 6'd2, W_DECODE));
    seq.push_back(st(0, 1, 6'd2, W_JEX));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL test_back_to_back step %0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    mem_ready   = 1'b1;
    opcode      = 6'd0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_addi();
    test_branch_illegal();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
